// File: rtl/branch_predict_bht.sv
// Branch history table predictor: a direct-mapped table of tagged 2-bit counters,
// swept clear after reset, with a static backward-taken fallback on a miss.
module branch_predict_bht #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] ins,
    output logic [31:0] target,
    output logic        taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        ready
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [INDEX_BITS-1:0] SWEEP_LAST = {INDEX_BITS{1'b1}};
    localparam logic [INDEX_BITS-1:0] SWEEP_ONE  = {{(INDEX_BITS-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        if (up) begin
            r = (c == 2'b11) ? 2'b11 : c + 2'b01;
        end else begin
            r = (c == 2'b00) ? 2'b00 : c - 2'b01;
        end
        return r;
    endfunction

    state_e                state_q;
    logic [INDEX_BITS-1:0] sweep_q;
    logic                  ready_q;

    logic                  valid_q [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q   [ENTRIES];
    logic [1:0]            ctr_q   [ENTRIES];

    logic                  op_32_s;
    logic                  op_branch_s;
    logic                  op_jal_s;
    logic [31:0]           imm_b_s;
    logic [31:0]           imm_j_s;

    logic [INDEX_BITS-1:0] pred_idx_s;
    logic [TAG_BITS-1:0]   pred_tag_s;
    logic                  pred_hit_s;
    logic [INDEX_BITS-1:0] upd_idx_s;
    logic [TAG_BITS-1:0]   upd_tag_s;
    logic                  upd_hit_s;

    logic                  wr_en_d;
    logic [INDEX_BITS-1:0] wr_idx_d;
    logic                  wr_valid_d;
    logic [TAG_BITS-1:0]   wr_tag_d;
    logic [1:0]            wr_ctr_d;

    logic                  unused_s;

    assign op_32_s     = (ins[1:0] == 2'b11);
    assign op_branch_s = op_32_s && (ins[6:2] == OP_BRANCH);
    assign op_jal_s    = op_32_s && (ins[6:2] == OP_JAL);
    assign imm_b_s     = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_j_s     = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};

    assign pred_idx_s  = pc[INDEX_BITS+1:2];
    assign pred_tag_s  = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign pred_hit_s  = ready_q && valid_q[pred_idx_s] && (tag_q[pred_idx_s] == pred_tag_s);

    assign upd_idx_s   = upd_pc[INDEX_BITS+1:2];
    assign upd_tag_s   = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign upd_hit_s   = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);

    assign unused_s    = ^{upd_pc[1:0], upd_pc >> (INDEX_BITS + TAG_BITS + 2)};

    assign ready       = ready_q;

    // Prediction: reads the table before any same-cycle update lands.
    always_comb begin
        target = pc + (op_branch_s ? imm_b_s : imm_j_s);
        if (op_jal_s) begin
            taken = 1'b1;
        end else if (op_branch_s && pred_hit_s) begin
            taken = ctr_q[pred_idx_s][1];
        end else if (op_branch_s) begin
            taken = ins[31];
        end else begin
            taken = 1'b0;
        end
    end

    // Single table write port, shared by the init sweep and trained updates.
    always_comb begin
        wr_en_d    = 1'b0;
        wr_idx_d   = sweep_q;
        wr_valid_d = 1'b0;
        wr_tag_d   = {TAG_BITS{1'b0}};
        wr_ctr_d   = 2'b01;
        if (rst) begin
            wr_en_d = 1'b0;
        end else if (state_q == ST_INIT) begin
            wr_en_d = 1'b1;
        end else if (upd_valid) begin
            wr_en_d    = 1'b1;
            wr_idx_d   = upd_idx_s;
            wr_valid_d = 1'b1;
            wr_tag_d   = upd_tag_s;
            if (upd_hit_s) begin
                wr_ctr_d = ctr_step(ctr_q[upd_idx_s], upd_taken);
            end else begin
                wr_ctr_d = upd_taken ? 2'b10 : 2'b01;
            end
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // Table storage.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            valid_q[wr_idx_d] <= wr_valid_d;
            tag_q[wr_idx_d]   <= wr_tag_d;
            ctr_q[wr_idx_d]   <= wr_ctr_d;
        end
    end

    // Init/run control: sweep every entry once, then raise ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= {INDEX_BITS{1'b0}};
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sweep_q <= sweep_q + SWEEP_ONE;
                    if (sweep_q == SWEEP_LAST) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                    sweep_q <= {INDEX_BITS{1'b0}};
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predict_bht.sv
// Self-checking bench for branch_predict_bht: directed vectors, corner sequences,
// and randomized traffic checked against an array-based reference model.
module tb_branch_predict_bht;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] target;
    logic        taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        ready;

    int n_vec;
    int n_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs [11];

    // reference model of the table
    bit m_valid [64];
    int m_tag   [64];
    int m_ctr   [64];

    branch_predict_bht #(.INDEX_BITS(6), .TAG_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .ins       (ins),
        .target    (target),
        .taken     (taken),
        .upd_valid (upd_valid),
        .upd_pc    (upd_pc),
        .upd_taken (upd_taken),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(input int off, input logic [2:0] f3);
        logic [12:0] o;
        o = off[12:0];
        return {o[12], o[10:5], 5'd2, 5'd1, f3, o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int off);
        logic [20:0] o;
        o = off[20:0];
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_check(input string nm);
        for (int c = 1; c <= 65; c++) begin
            @(negedge clk);
            chk(nm, {31'd0, ready}, (c == 65) ? 32'd1 : 32'd0);
        end
        tick();
    endtask

    task automatic upd(input logic [31:0] a, input logic t);
        upd_valid = 1'b1;
        upd_pc    = a;
        upd_taken = t;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic pred(input string nm, input logic [31:0] a, input logic [31:0] i,
                        input logic exp_t, input logic [31:0] exp_tg);
        pc  = a;
        ins = i;
        @(negedge clk);
        chk(nm, {31'd0, taken}, {31'd0, exp_t});
        chk({nm, "_target"}, target, exp_tg);
        tick();
    endtask

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd64);
    endfunction

    function automatic int m_tg(input logic [31:0] a);
        return int'((a / 32'd256) % 32'd256);
    endfunction

    function automatic logic [31:0] rand_addr();
        int tags [4];
        tags[0] = 1; tags[1] = 2; tags[2] = 'h41; tags[3] = 'hFF;
        return (32'($urandom_range(0, 3)) << 16) | (32'(tags[$urandom_range(0, 3)]) << 8)
             | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        int          off;
        int          kind;
        int          mi;
        logic [31:0] a;
        logic [31:0] ua;
        logic        ut;
        logic        uv;
        logic        exp_t;

        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        pc        = 32'h0;
        ins       = 32'h0000_0013;
        upd_valid = 1'b0;
        upd_pc    = 32'h0;
        upd_taken = 1'b0;

        // init: 3 reset cycles, then a 64-cycle sweep
        repeat (3) tick();
        @(negedge clk);
        chk("ready_in_rst", {31'd0, ready}, 32'd0);
        tick();
        rst = 1'b0;
        sweep_check("init_sweep");

        // reset sampled in RUN drops ready on the next cycle
        rst = 1'b1;
        tick();
        chk("ready_after_rst", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        repeat (29) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep_check("init_restart");

        // static fallback vectors on an empty table
        vecs[0]  = '{32'h0000_0100, enc_b(-8, 3'd0),       1'b1, 32'h0000_00F8};
        vecs[1]  = '{32'h0000_0100, enc_b(8, 3'd0),        1'b0, 32'h0000_0108};
        vecs[2]  = '{32'h0000_0100, enc_j('h800),          1'b1, 32'h0000_0900};
        vecs[3]  = '{32'h0000_2000, enc_b(-4096, 3'd1),    1'b1, 32'h0000_1000};
        vecs[4]  = '{32'h0000_2000, enc_b(4094, 3'd5),     1'b0, 32'h0000_2FFE};
        vecs[5]  = '{32'h0000_0010, enc_j(-16),            1'b1, 32'h0000_0000};
        vecs[6]  = '{32'hFFFF_FFF0, enc_j(32),             1'b1, 32'h0000_0010};
        vecs[7]  = '{32'h0000_0300, 32'h0000_0013,         1'b0, 32'h0000_0300};
        vecs[8]  = '{32'h0000_0300, 32'h0000_0060,         1'b0, 32'h0000_0300};
        vecs[9]  = '{32'h0000_0300, 32'h8000_0013,         1'b0, 32'hFFF0_0300};
        vecs[10] = '{32'h0020_0000, enc_j(-1048576),       1'b1, 32'h0010_0000};
        for (int v = 0; v < 11; v++) begin
            pred($sformatf("vec%0d", v), vecs[v].pc, vecs[v].ins, vecs[v].exp_taken, vecs[v].exp_target);
        end

        // training: 01 -> 00, then up to saturation and back down
        upd(32'h100, 1'b0);
        upd(32'h100, 1'b0);
        pred("train_nt2", 32'h100, enc_b(-8, 3'd0), 1'b0, 32'hF8);
        upd(32'h100, 1'b1);
        pred("train_t1", 32'h100, enc_b(-8, 3'd0), 1'b0, 32'hF8);
        upd(32'h100, 1'b1);
        pred("train_t2", 32'h100, enc_b(8, 3'd0), 1'b1, 32'h108);
        upd(32'h100, 1'b1);
        pred("train_t3", 32'h100, enc_b(8, 3'd0), 1'b1, 32'h108);
        upd(32'h100, 1'b1);
        pred("train_t4_sat", 32'h100, enc_b(8, 3'd0), 1'b1, 32'h108);
        upd(32'h100, 1'b0);
        pred("train_down1", 32'h100, enc_b(8, 3'd0), 1'b1, 32'h108);
        upd(32'h100, 1'b0);
        pred("train_down2", 32'h100, enc_b(8, 3'd0), 1'b0, 32'h108);

        // aliasing: same index, different tag replaces the entry
        upd(32'h4100, 1'b1);
        pred("alias_old_miss", 32'h100, enc_b(8, 3'd0), 1'b0, 32'h108);
        pred("alias_new_hit", 32'h4100, enc_b(8, 3'd0), 1'b1, 32'h4108);

        // same-cycle update and prediction on one entry
        upd(32'h100, 1'b0);
        pc        = 32'h100;
        ins       = enc_b(8, 3'd0);
        upd_valid = 1'b1;
        upd_pc    = 32'h100;
        upd_taken = 1'b1;
        @(negedge clk);
        chk("conflict_same", {31'd0, taken}, 32'd0);
        tick();
        upd_valid = 1'b0;
        @(negedge clk);
        chk("conflict_next", {31'd0, taken}, 32'd1);
        tick();

        // table ignored while in reset, then update dropped during init
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_static", {31'd0, taken}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (9) tick();
        upd(32'h100, 1'b1);
        repeat (54) tick();
        chk("drop_ready", {31'd0, ready}, 32'd1);
        pred("drop_not_valid", 32'h100, enc_b(8, 3'd0), 1'b0, 32'h108);

        // random traffic vs reference model (table empty here)
        for (int e = 0; e < 64; e++) begin
            m_valid[e] = 1'b0;
            m_tag[e]   = 0;
            m_ctr[e]   = 1;
        end
        for (int n = 0; n < 400; n++) begin
            a    = rand_addr();
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                off = $urandom_range(0, 4095) * 2 - 4096;
                ins = enc_b(off, 3'd0);
            end else if (kind == 2) begin
                off = $urandom_range(0, 1048575) * 2 - 1048576;
                ins = enc_j(off);
            end else begin
                off = 0;
                ins = 32'h0000_0013;
            end
            uv = ($urandom_range(0, 1) == 1);
            ua = rand_addr();
            ut = ($urandom_range(0, 1) == 1);
            pc        = a;
            upd_valid = uv;
            upd_pc    = ua;
            upd_taken = ut;

            mi = m_idx(a);
            if (kind == 2) begin
                exp_t = 1'b1;
            end else if (kind == 3) begin
                exp_t = 1'b0;
            end else if (m_valid[mi] && m_tag[mi] == m_tg(a)) begin
                exp_t = (m_ctr[mi] >= 2);
            end else begin
                exp_t = (off < 0);
            end

            @(negedge clk);
            chk($sformatf("rand%0d_taken", n), {31'd0, taken}, {31'd0, exp_t});
            chk($sformatf("rand%0d_target", n), target, a + 32'(off));

            if (uv) begin
                mi = m_idx(ua);
                if (m_valid[mi] && m_tag[mi] == m_tg(ua)) begin
                    m_ctr[mi] = ut ? ((m_ctr[mi] == 3) ? 3 : m_ctr[mi] + 1)
                                   : ((m_ctr[mi] == 0) ? 0 : m_ctr[mi] - 1);
                end else begin
                    m_valid[mi] = 1'b1;
                    m_tag[mi]   = m_tg(ua);
                    m_ctr[mi]   = ut ? 2 : 1;
                end
            end
            tick();
        end
        upd_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predict_bht.md
BRANCH_PREDICT_BHT -- requirements
Module: branch_predict_bht

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, giving a table of 2^INDEX_BITS entries (legal range 2..10).
REQ-002 SHALL have parameter TAG_BITS, default 8, giving per-entry tag width (legal range 1..(30-INDEX_BITS)).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port pc, input, 32, fetch address of the instruction being predicted.
REQ-006 SHALL have port ins, input, 32, fetched instruction word.
REQ-007 SHALL have port target, output, 32, predicted target address.
REQ-008 SHALL have port taken, output, 1, predict redirect to target.
REQ-009 SHALL have port upd_valid, input, 1, a resolved conditional branch is presented this cycle.
REQ-010 SHALL have port upd_pc, input, 32, address of the resolved branch.
REQ-011 SHALL have port upd_taken, input, 1, actual outcome of the resolved branch.
REQ-012 SHALL have port ready, output, 1, table initialised and in use.

Function
REQ-013 SHALL decode op_32 = (ins[1:0]==2'b11), op_branch = op_32 and ins[6:2]==OP_BRANCH, op_jal = op_32 and ins[6:2]==OP_JAL, with the opcode values from control.vh.
REQ-014 SHALL compute target = pc + imm_b when op_branch, else pc + imm_j, using the standard RV32 B/J immediates, sign-extended and bit 0 zero, modulo 2^32.
REQ-015 SHALL hold per entry: valid (1 bit), tag (TAG_BITS), ctr (2-bit saturating counter).
REQ-016 SHALL form index = addr[INDEX_BITS+1:2] and tag = addr[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2] for both pc and upd_pc.
REQ-017 SHALL define hit = ready and entry[index(pc)].valid and entry tag == tag(pc).
REQ-018 SHALL drive taken combinationally, same cycle as pc/ins: op_jal -> 1; op_branch and hit -> ctr[1]; op_branch and not hit -> ins[31] (static backward-taken); otherwise 0.
REQ-019 SHALL implement states INIT and RUN; rst high forces INIT with sweep counter 0.
REQ-020 SHALL, in INIT with rst low, clear valid and set ctr=2'b01 of entry[sweep] each cycle and increment sweep; after entry 2^INDEX_BITS-1 is cleared, SHALL enter RUN.
REQ-021 SHALL hold ready=0 in INIT and ready=1 in RUN; ready rises the cycle after the last entry is cleared, i.e. 2^INDEX_BITS cycles after rst falls.
REQ-022 SHALL ignore upd_valid while ready=0; the table is not modified.
REQ-023 SHALL, on upd_valid in RUN with update hit (valid and tag match at index(upd_pc)), increment ctr if upd_taken, else decrement, saturating at 2'b11 and 2'b00.
REQ-024 SHALL, on upd_valid in RUN with update miss, allocate the entry: valid=1, tag=tag(upd_pc), ctr = upd_taken ? 2'b10 : 2'b01.
REQ-025 SHALL, when an update and a prediction address the same entry in one cycle, give the prediction the pre-update value; the update is visible the next cycle.
REQ-026 SHALL, on rst asserted mid-INIT or mid-RUN, discard table contents and restart the sweep from entry 0 on the cycle after rst falls.
REQ-027 SHALL perform at most one table write per cycle.

Reset
REQ-028 SHALL drive ready=0 in the cycle after any rising clock edge sampling rst=1.
REQ-029 SHALL leave taken/target purely combinational; during reset and INIT they follow the static rule of REQ-018.

Verification (INDEX_BITS=6, TAG_BITS=8)
REQ-030 SHALL check init: rst high 3 cycles then low -> ready=0 for 64 cycles, ready=1 on the 65th; reassert rst at cycle 30 -> full 64-cycle sweep restarts.
REQ-031 SHALL check static fallback: ready=1, empty table, pc=0x100, BEQ offset -8 -> taken=1, target=0xF8; offset +8 -> taken=0, target=0x108; JAL offset +0x800 -> taken=1, target=0x900.
REQ-032 SHALL check training: updates pc=0x100 taken=0 twice -> ctr 01 then 00, backward BEQ at 0x100 predicts taken=0; then 3 taken updates -> ctr 11, taken=1; a 4th saturates at 11.
REQ-033 SHALL check aliasing: allocate 0x100, then update 0x4100 (same index, different tag) taken=1 -> entry replaced with ctr=10; forward BEQ at 0x100 now misses -> static taken=0.
REQ-034 SHALL check same-cycle conflict: ctr=01 at 0x100, update taken=1 while predicting 0x100 -> taken=0 that cycle, taken=1 next cycle.
REQ-035 SHALL check updates during INIT are dropped: upd_valid at sweep cycle 10 -> after ready, entry reads not valid.
